// File: rtl/ps2_keyboard_tx.sv
// ps2_keyboard_tx: PS/2 device-side transmitter (keyboard model).
// Scan-code bytes are queued in a small FIFO and serialised as 11-bit
// frames (start, 8 data LSB first, odd parity, stop) on ps2_clk/ps2_data.
// Optional feature macro: PS2_TX_ERRINJ_EN adds the err_inject input, which
// inverts the parity bit of the frame popped while it is high.
module ps2_keyboard_tx #(
   parameter int CLK_DIV    = 4,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [7:0]                    in_data,
`ifdef PS2_TX_ERRINJ_EN
   input  logic                          err_inject,
`endif
   output logic                          ps2_clk,
   output logic                          ps2_data,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [PW-1:0] PHASE_LAST = PW'(CLK_DIV - 1);
   localparam logic [AW:0]   COUNT_FULL = (AW + 1)'(FIFO_DEPTH);
   localparam logic [3:0]    LAST_BIT   = 4'd10;

   typedef enum logic [1:0] {
      IDLE,
      HIGH,
      LOW,
      GAP
   } state_t;

   state_t          state;
   logic [PW-1:0]   phaseCnt;
   logic [3:0]      bitIdx;
   logic            gapSecond;
   logic [10:0]     shiftReg;

   logic [7:0]      fifoMem [FIFO_DEPTH];
   logic [AW-1:0]   wrPtr;
   logic [AW-1:0]   rdPtr;
   logic [AW:0]     count;

   logic            push;
   logic            pop;
   logic            phaseDone;
   logic            injParity;
   logic [7:0]      popData;

`ifdef PS2_TX_ERRINJ_EN
   assign injParity = err_inject;
`else
   assign injParity = 1'b0;
`endif

   // A full FIFO refuses a push even when a pop happens in the same cycle.
   assign in_ready   = (count != COUNT_FULL);
   assign push       = in_valid && in_ready;
   // Pop decision uses the registered count, so a fresh push is seen one cycle later.
   assign pop        = (state == IDLE) && (count != '0);
   assign busy       = (state != IDLE);
   assign fifo_count = count;
   assign phaseDone  = (phaseCnt == PHASE_LAST);
   assign popData    = fifoMem[rdPtr];

   // FIFO storage: written on push, no reset so it maps onto RAM.
   always_ff @(posedge clock) begin
      if (push) begin
         fifoMem[wrPtr] <= in_data;
      end
   end

   // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wrPtr <= '0;
         rdPtr <= '0;
         count <= '0;
      end else begin
         if (push) begin
            wrPtr <= wrPtr + 1'b1;
         end
         if (pop) begin
            rdPtr <= rdPtr + 1'b1;
         end
         if (push && !pop) begin
            count <= count + 1'b1;
         end else if (pop && !push) begin
            count <= count - 1'b1;
         end
      end
   end

   // Frame sequencer; the PS/2 lines are registered from the current state,
   // so a new bit lands on ps2_data at the same edge ps2_clk returns high.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         phaseCnt  <= '0;
         bitIdx    <= '0;
         gapSecond <= 1'b0;
         shiftReg  <= '1;
         ps2_clk   <= 1'b1;
         ps2_data  <= 1'b1;
      end else begin
         ps2_clk  <= (state != LOW);
         ps2_data <= (state == HIGH || state == LOW) ? shiftReg[0] : 1'b1;

         case (state)
            IDLE: begin
               if (pop) begin
                  shiftReg <= {1'b1, (~^popData) ^ injParity, popData, 1'b0};
                  bitIdx   <= '0;
                  phaseCnt <= '0;
                  state    <= HIGH;
               end
            end
            HIGH: begin
               if (phaseDone) begin
                  phaseCnt <= '0;
                  state    <= LOW;
               end else begin
                  phaseCnt <= phaseCnt + 1'b1;
               end
            end
            LOW: begin
               if (phaseDone) begin
                  phaseCnt <= '0;
                  shiftReg <= {1'b1, shiftReg[10:1]};
                  if (bitIdx < LAST_BIT) begin
                     bitIdx <= bitIdx + 1'b1;
                     state  <= HIGH;
                  end else begin
                     gapSecond <= 1'b0;
                     state     <= GAP;
                  end
               end else begin
                  phaseCnt <= phaseCnt + 1'b1;
               end
            end
            GAP: begin
               // Two phase-counter periods; gapSecond marks the second one.
               if (phaseDone) begin
                  phaseCnt <= '0;
                  if (gapSecond) begin
                     state <= IDLE;
                  end else begin
                     gapSecond <= 1'b1;
                  end
               end else begin
                  phaseCnt <= phaseCnt + 1'b1;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ps2_keyboard_tx.sv
// tb_ps2_keyboard_tx: self-checking bench for ps2_keyboard_tx.
// A line monitor decodes frames from the PS/2 pins; tests compare decoded
// frames against a table and against a byte-queue reference model.
module tb_ps2_keyboard_tx;

   localparam int CLK_DIV      = 4;
   localparam int FIFO_DEPTH   = 4;
   localparam int FRAME_PERIOD = 24 * CLK_DIV + 1;
   localparam int FRAME_WAIT   = 8 * FRAME_PERIOD;

   logic       clock    = 1'b0;
   logic       reset    = 1'b0;
   logic       in_valid = 1'b0;
   logic [7:0] in_data  = 8'h00;
   logic       in_ready;
   logic       ps2_clk;
   logic       ps2_data;
   logic       busy;
   logic [2:0] fifo_count;
`ifdef PS2_TX_ERRINJ_EN
   logic       err_inject = 1'b0;
`endif

   ps2_keyboard_tx #(
      .CLK_DIV    (CLK_DIV),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
`ifdef PS2_TX_ERRINJ_EN
      .err_inject (err_inject),
`endif
      .ps2_clk    (ps2_clk),
      .ps2_data   (ps2_data),
      .busy       (busy),
      .fifo_count (fifo_count)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [10:0] bits;
      int          startAt;
      int          firstFall;
      bit          timingOk;
   } frame_t;

   typedef struct {
      logic [7:0]  data;
      logic [10:0] frame;
   } vec_t;

   frame_t      frameQ[$];
   frame_t      monFrame;
   int          sampleIdx   = 0;
   logic        prevClk     = 1'b1;
   bit          inFrame     = 1'b0;
   int          bitCnt      = 0;
   int          monStart    = 0;
   int          monFirst    = 0;
   bit          monTimingOk = 1'b1;
   logic [10:0] monBits     = '0;

   int nChecks = 0;
   int nFails  = 0;

   // Line monitor: sample mid-cycle, decode one bit per ps2_clk falling edge
   // and check each falling edge lands at CLK_DIV*(2i+1) after the start bit.
   always @(negedge clock) begin
      sampleIdx++;
      if (!reset) begin
         inFrame = 1'b0;
         bitCnt  = 0;
      end else begin
         if (!inFrame && ps2_clk && !ps2_data) begin
            inFrame     = 1'b1;
            monStart    = sampleIdx;
            bitCnt      = 0;
            monTimingOk = 1'b1;
            monBits     = '0;
         end
         if (inFrame && prevClk && !ps2_clk) begin
            if (bitCnt == 0) monFirst = sampleIdx - monStart;
            if (sampleIdx - monStart != CLK_DIV * (2 * bitCnt + 1)) monTimingOk = 1'b0;
            monBits[bitCnt] = ps2_data;
            bitCnt++;
            if (bitCnt == 11) begin
               monFrame.bits      = monBits;
               monFrame.startAt   = monStart;
               monFrame.firstFall = monFirst;
               monFrame.timingOk  = monTimingOk;
               frameQ.push_back(monFrame);
               inFrame = 1'b0;
            end
         end
      end
      prevClk = ps2_clk;
   end

   // Reference frame built from the protocol rule: odd total of ones over data+parity.
   function automatic logic [10:0] refFrame(input logic [7:0] b, input bit invertParity);
      logic par;
      par = ($countones(b) % 2 == 0) ? 1'b1 : 1'b0;
      if (invertParity) par = ~par;
      return {1'b1, par, b, 1'b0};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nChecks++;
      if (act !== exp) begin
         nFails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end else begin
         $display("ok   %s: 0x%0h", name, act);
      end
   endtask

   task automatic stepCycle();
      @(negedge clock);
      #1;
   endtask

   task automatic waitUntil(input int target);
      while (sampleIdx < target) stepCycle();
   endtask

   task automatic pushByte(input logic [7:0] b, output int pushSample);
      stepCycle();
      in_valid   = 1'b1;
      in_data    = b;
      pushSample = sampleIdx;
      chk("push_ready", in_ready, 1);
      stepCycle();
      in_valid = 1'b0;
   endtask

   task automatic waitFrame(input string name, output frame_t f);
      int  t;
      bit  got;
      t = 0;
      while (frameQ.size() == 0 && t < FRAME_WAIT) begin
         stepCycle();
         t++;
      end
      got = (frameQ.size() != 0);
      chk({name, "_arrived"}, got, 1);
      if (got) begin
         f = frameQ.pop_front();
      end else begin
         f.bits      = '0;
         f.startAt   = 0;
         f.firstFall = 0;
         f.timingOk  = 1'b0;
      end
   endtask

   task automatic waitIdle();
      int t;
      t = 0;
      while (busy && t < FRAME_WAIT) begin
         stepCycle();
         t++;
      end
      chk("idle_reached", busy, 0);
   endtask

   task automatic resetDut();
      stepCycle();
      reset = 1'b0;
      repeat (3) stepCycle();
      reset = 1'b1;
   endtask

   // Watchdog so the run always terminates.
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t       vecs[5];
      frame_t     f;
      int         p;
      int         bad;
      int         prevStart;
      logic [7:0] modelQ[$];
      logic [7:0] b;

      vecs[0] = '{8'h1C, 11'h438};
      vecs[1] = '{8'hFF, 11'h7FE};
      vecs[2] = '{8'h01, 11'h402};
      vecs[3] = '{8'h00, 11'h600};
      vecs[4] = '{8'h80, 11'h500};

      // Reset values while reset is held.
      stepCycle();
      chk("reset_ps2_clk", ps2_clk, 1);
      chk("reset_ps2_data", ps2_data, 1);
      chk("reset_busy", busy, 0);
      chk("reset_fifo_count", fifo_count, 0);
      chk("reset_in_ready", in_ready, 1);
      stepCycle();
      reset = 1'b1;

      // Idle stability: no pushes for 1000 cycles.
      bad = 0;
      for (int i = 0; i < 1000; i++) begin
         stepCycle();
         if (ps2_clk !== 1'b1 || ps2_data !== 1'b1 || busy !== 1'b0) bad++;
      end
      chk("idle_bad_samples", bad, 0);
      chk("idle_no_frames", frameQ.size(), 0);

      // Table-driven single-byte frames.
      for (int i = 0; i < 5; i++) begin
         pushByte(vecs[i].data, p);
         waitFrame($sformatf("vec%0d", i), f);
         chk($sformatf("vec%0d_bits", i), f.bits, vecs[i].frame);
         chk($sformatf("vec%0d_timing", i), f.timingOk, 1);
         chk($sformatf("vec%0d_first_fall", i), f.firstFall, CLK_DIV);
         chk($sformatf("vec%0d_latency", i), f.startAt - p, 3);
         waitUntil(f.startAt + 24 * CLK_DIV - 2);
         chk($sformatf("vec%0d_busy_in_gap", i), busy, 1);
         stepCycle();
         chk($sformatf("vec%0d_busy_after_gap", i), busy, 0);
         waitIdle();
      end

      // FIFO fill: in_valid high for 6 consecutive cycles after reset.
      resetDut();
      modelQ.delete();
      stepCycle();
      for (int k = 0; k < 6; k++) begin
         in_valid = 1'b1;
         in_data  = 8'h10 + 8'(k);
         if (in_ready) modelQ.push_back(in_data);
         if (k == 5) begin
            chk("fill_in_ready_cycle5", in_ready, 0);
            chk("fill_count_full", fifo_count, 4);
         end
         stepCycle();
      end
      in_valid = 1'b0;
      chk("fill_accepted", modelQ.size(), 5);
      prevStart = 0;
      for (int i = 0; i < 5; i++) begin
         waitFrame($sformatf("fill%0d", i), f);
         b = (modelQ.size() != 0) ? modelQ.pop_front() : 8'h00;
         chk($sformatf("fill%0d_bits", i), f.bits, refFrame(b, 1'b0));
         chk($sformatf("fill%0d_timing", i), f.timingOk, 1);
         if (i > 0) chk($sformatf("fill%0d_spacing", i), f.startAt - prevStart, FRAME_PERIOD);
         prevStart = f.startAt;
      end
      waitIdle();

      // Reset mid-frame during data bit 3 (clock-low phase) of 0xAA.
      pushByte(8'hAA, p);
      pushByte(8'h33, p);
      waitUntil(p + 3);
      chk("midreset_in_frame", inFrame, 1);
      waitUntil(monStart + 9 * CLK_DIV + 1);
      chk("midreset_clk_low_before", ps2_clk, 0);
      chk("midreset_count_before", fifo_count, 1);
      reset = 1'b0;
      #1;
      chk("midreset_ps2_clk", ps2_clk, 1);
      chk("midreset_ps2_data", ps2_data, 1);
      chk("midreset_fifo_count", fifo_count, 0);
      chk("midreset_busy", busy, 0);
      repeat (3) stepCycle();
      reset = 1'b1;
      repeat (30 * CLK_DIV) stepCycle();
      chk("midreset_no_resume", frameQ.size(), 0);
      chk("midreset_idle_busy", busy, 0);
      pushByte(8'h5A, p);
      waitFrame("after_reset", f);
      chk("after_reset_bits", f.bits, 11'h6B4);
      chk("after_reset_timing", f.timingOk, 1);
      waitIdle();

`ifdef PS2_TX_ERRINJ_EN
      // Error injection: parity inverted for the frame popped with err_inject=1.
      err_inject = 1'b1;
      pushByte(8'h1C, p);
      stepCycle();
      err_inject = 1'b0;
      waitFrame("errinj", f);
      chk("errinj_bits", f.bits, 11'h638);
      chk("errinj_timing", f.timingOk, 1);
      waitIdle();
`endif

      // Randomised traffic against the byte-queue model.
      modelQ.delete();
      bad = 0;
      for (int i = 0; i < 400; i++) begin
         stepCycle();
         in_valid = ($urandom_range(0, 3) == 0);
         in_data  = 8'($urandom);
         #1;
         if (in_ready !== (fifo_count != 3'(FIFO_DEPTH))) bad++;
         if (fifo_count > 3'(FIFO_DEPTH)) bad++;
         if (in_valid && in_ready) modelQ.push_back(in_data);
      end
      stepCycle();
      in_valid = 1'b0;
      chk("rand_ready_consistent", bad, 0);
      $display("info random bytes accepted: %0d", modelQ.size());
      while (modelQ.size() != 0) begin
         b = modelQ.pop_front();
         waitFrame("rand", f);
         chk($sformatf("rand_bits_%02h", b), f.bits, refFrame(b, 1'b0));
         chk($sformatf("rand_timing_%02h", b), f.timingOk, 1);
      end
      waitIdle();
      repeat (4 * CLK_DIV) stepCycle();
      chk("rand_no_extra_frames", frameQ.size(), 0);
      chk("rand_final_count", fifo_count, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
